// File: rtl/mem_access_seq_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_access_seq_pkg;

    // Sequencer states.
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        CHECK = 4'd1,
        READ  = 4'd2,
        LATCH = 4'd3,
        MERGE = 4'd4,
        WRITE = 4'd5,
        WB    = 4'd6,
        DONE  = 4'd7,
        ERR   = 4'd8
    } state_t;

    // Access size codes; 2'b00 is illegal.
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // A word store overwrites the whole word, so it skips the read-modify phase.
    function automatic logic needs_read(input logic is_store, input logic [1:0] size);
        return !(is_store && (size == SZ_WORD));
    endfunction

endpackage

// File: rtl/mem_align_check.sv
// Combinational size/alignment fault decode for a captured request.
module mem_align_check
    import mem_access_seq_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic       fault_o
);

    // Illegal size code, odd halfword, or non-word-aligned word.
    always_comb begin
        fault_o = 1'b0;
        case (size_i)
            SZ_BYTE: fault_o = 1'b0;
            SZ_HALF: fault_o = addr_lo_i[0];
            SZ_WORD: fault_o = (addr_lo_i != 2'b00);
            default: fault_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// Load/store sequencer: captures one request, checks alignment, reads the
// word when a merge is needed, drives the merge unit, then writes memory or
// the register file and pulses done (or err on a fault).
module mem_access_seq
    import mem_access_seq_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int ADDR_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mdr_load,
    output logic [1:0]        ls_size,
    output logic              ls_store,
    output logic              ls_en,
    output logic              reg_write,
    output logic              done,
    output logic              err
);

    // Counter preload so READ lasts exactly MEM_LAT cycles (counts down to 0).
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              store_q, store_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              fault;

    mem_align_check u_align (
        .size_i    (size_q),
        .addr_lo_i (addr_q[1:0]),
        .fault_o   (fault)
    );

    // State, wait counter and captured request registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            store_q <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            store_q <= store_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
        end
    end

    // Next-state, capture and output decode; outputs depend only on registers.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        store_d   = store_q;
        size_d    = size_q;
        addr_d    = addr_q;
        busy      = (state_q != IDLE);
        mem_addr  = '0;
        ls_size   = 2'b00;
        ls_store  = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mdr_load  = 1'b0;
        ls_en     = 1'b0;
        reg_write = 1'b0;
        done      = 1'b0;
        err       = 1'b0;

        if (state_q != IDLE) begin
            mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
            ls_size  = size_q;
            ls_store = store_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    store_d = is_store;
                    size_d  = size;
                    addr_d  = addr;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (fault) begin
                    state_d = ERR;
                end else if (needs_read(store_q, size_q)) begin
                    cnt_d   = LAT_M1;
                    state_d = READ;
                end else begin
                    state_d = MERGE;
                end
            end
            READ: begin
                mem_rd = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = LATCH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            LATCH: begin
                mdr_load = 1'b1;
                state_d  = MERGE;
            end
            MERGE: begin
                ls_en   = 1'b1;
                state_d = store_q ? WRITE : WB;
            end
            WRITE: begin
                mem_wr  = 1'b1;
                state_d = DONE;
            end
            WB: begin
                reg_write = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                err     = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: two instances (MEM_LAT=1 and 3) share
// stimulus; per-cycle strobe patterns are compared against hand tables.
module tb_mem_access_seq;
    import mem_access_seq_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        is_store;
    logic [1:0]  size;
    logic [31:0] addr;

    logic        busy1, mem_rd1, mem_wr1, mdr_load1, ls_store1, ls_en1, reg_write1, done1, err1;
    logic [31:0] mem_addr1;
    logic [1:0]  ls_size1;
    logic        busy3, mem_rd3, mem_wr3, mdr_load3, ls_store3, ls_en3, reg_write3, done3, err3;
    logic [31:0] mem_addr3;
    logic [1:0]  ls_size3;

    logic [6:0]  strb1, strb3;

    int n_chk = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    mem_access_seq #(.MEM_LAT(1), .ADDR_W(32)) dut1 (
        .clock(clock), .reset(reset), .start(start), .is_store(is_store),
        .size(size), .addr(addr), .busy(busy1), .mem_addr(mem_addr1),
        .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mdr_load(mdr_load1),
        .ls_size(ls_size1), .ls_store(ls_store1), .ls_en(ls_en1),
        .reg_write(reg_write1), .done(done1), .err(err1)
    );

    mem_access_seq #(.MEM_LAT(3), .ADDR_W(32)) dut3 (
        .clock(clock), .reset(reset), .start(start), .is_store(is_store),
        .size(size), .addr(addr), .busy(busy3), .mem_addr(mem_addr3),
        .mem_rd(mem_rd3), .mem_wr(mem_wr3), .mdr_load(mdr_load3),
        .ls_size(ls_size3), .ls_store(ls_store3), .ls_en(ls_en3),
        .reg_write(reg_write3), .done(done3), .err(err3)
    );

    // Strobe bits: {mem_rd, mem_wr, mdr_load, ls_en, reg_write, done, err}
    assign strb1 = {mem_rd1, mem_wr1, mdr_load1, ls_en1, reg_write1, done1, err1};
    assign strb3 = {mem_rd3, mem_wr3, mdr_load3, ls_en3, reg_write3, done3, err3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request and compare cycles 1..n after the start cycle.
    // seq[7*k +: 7] is the expected strobe word in cycle k; bsy[k] is busy.
    task automatic run_seq(input string tag, input bit sel3, input bit hold,
                           input logic st, input logic [1:0] sz, input logic [31:0] a,
                           input int n, input logic [83:0] seq, input logic [11:0] bsy,
                           input logic [31:0] exp_addr, input logic [2:0] exp_ls);
        logic [6:0]  s;
        logic        b;
        logic [31:0] ma;
        logic [2:0]  ls;
        @(negedge clock);
        start = 1'b1; is_store = st; size = sz; addr = a;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (!hold) start = 1'b0;
            s  = sel3 ? strb3 : strb1;
            b  = sel3 ? busy3 : busy1;
            ma = sel3 ? mem_addr3 : mem_addr1;
            ls = sel3 ? {ls_size3, ls_store3} : {ls_size1, ls_store1};
            chk($sformatf("%s c%0d strobes", tag, k), 32'(s), 32'(seq[7*k +: 7]));
            chk($sformatf("%s c%0d busy", tag, k), 32'(b), 32'(bsy[k]));
            if (k == 1) chk($sformatf("%s mem_addr", tag), ma, exp_addr);
            if (seq[7*k + 3]) chk($sformatf("%s c%0d ls_size/store", tag, k), 32'(ls), 32'(exp_ls));
        end
        start = 1'b0;
        if (!hold) begin
            @(negedge clock);
            b  = sel3 ? busy3 : busy1;
            ma = sel3 ? mem_addr3 : mem_addr1;
            ls = sel3 ? {ls_size3, ls_store3} : {ls_size1, ls_store1};
            chk($sformatf("%s idle busy", tag), 32'(b), 32'd0);
            chk($sformatf("%s idle addr/ls", tag), ma | 32'(ls), 32'd0);
        end
        repeat (4) @(negedge clock);
    endtask

    logic [6:0] acc;

    initial begin
        // Reset with start asserted: reset wins, everything reads zero.
        reset = 1'b1; start = 1'b1; is_store = 1'b1; size = SZ_WORD; addr = 32'h40;
        repeat (3) @(negedge clock);
        chk("rst busy1", 32'(busy1), 0);
        chk("rst strb1", 32'(strb1), 0);
        chk("rst out1", mem_addr1 | 32'({ls_size1, ls_store1}), 0);
        chk("rst busy3", 32'(busy3), 0);
        chk("rst strb3", 32'(strb3), 0);
        chk("rst out3", mem_addr3 | 32'({ls_size3, ls_store3}), 0);
        start = 1'b0; reset = 1'b0;
        @(negedge clock);
        chk("post-rst busy1", 32'(busy1), 0);

        // Load byte, MEM_LAT=1: rd@2 mdr@3 ls_en@4 reg_write@5 done@6
        run_seq("lb", 1'b0, 1'b0, 1'b0, SZ_BYTE, 32'h13, 6,
                {7'h02, 7'h04, 7'h08, 7'h10, 7'h40, 7'h00, 7'h00},
                12'hFFE, 32'h10, 3'b010);

        // Store half, MEM_LAT=3: rd@2-4 mdr@5 ls_en@6 mem_wr@7 done@8
        run_seq("sh", 1'b1, 1'b0, 1'b1, SZ_HALF, 32'h22, 8,
                {7'h02, 7'h20, 7'h08, 7'h10, 7'h40, 7'h40, 7'h40, 7'h00, 7'h00},
                12'hFFE, 32'h20, 3'b101);

        // Load word, MEM_LAT=3: rd@2-4 mdr@5 ls_en@6 reg_write@7 done@8
        run_seq("lw3", 1'b1, 1'b0, 1'b0, SZ_WORD, 32'h84, 8,
                {7'h02, 7'h04, 7'h08, 7'h10, 7'h40, 7'h40, 7'h40, 7'h00, 7'h00},
                12'hFFE, 32'h84, 3'b110);

        // Store word: no read, ls_en@2 mem_wr@3 done@4
        run_seq("sw", 1'b0, 1'b0, 1'b1, SZ_WORD, 32'h40, 4,
                {7'h02, 7'h20, 7'h08, 7'h00, 7'h00},
                12'hFFE, 32'h40, 3'b111);

        // Faults: err@2 with nothing else
        run_seq("lw misalign", 1'b0, 1'b0, 1'b0, SZ_WORD, 32'h42, 2,
                {7'h01, 7'h00, 7'h00}, 12'hFFE, 32'h40, 3'b000);
        run_seq("size00", 1'b0, 1'b0, 1'b0, 2'b00, 32'h10, 2,
                {7'h01, 7'h00, 7'h00}, 12'hFFE, 32'h10, 3'b000);
        run_seq("sh odd", 1'b1, 1'b0, 1'b1, SZ_HALF, 32'h21, 2,
                {7'h01, 7'h00, 7'h00}, 12'hFFE, 32'h20, 3'b000);

        // Reset during READ of a store (MEM_LAT=3 instance).
        @(negedge clock);
        start = 1'b1; is_store = 1'b1; size = SZ_HALF; addr = 32'h22;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        chk("abort in READ", 32'(mem_rd3), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort busy", 32'(busy3), 0);
        chk("abort strb", 32'(strb3), 0);
        chk("abort out", mem_addr3 | 32'({ls_size3, ls_store3}), 0);
        acc = 7'd0;
        repeat (8) begin
            @(negedge clock);
            acc = acc | strb3;
        end
        chk("abort no pulses", 32'(acc), 0);
        run_seq("sw after abort", 1'b1, 1'b0, 1'b1, SZ_WORD, 32'h40, 4,
                {7'h02, 7'h20, 7'h08, 7'h00, 7'h00},
                12'hFFE, 32'h40, 3'b111);

        // start held high: second word store begins only after returning to IDLE.
        run_seq("sw held", 1'b0, 1'b1, 1'b1, SZ_WORD, 32'h40, 10,
                {7'h00, 7'h02, 7'h20, 7'h08, 7'h00, 7'h00, 7'h02, 7'h20, 7'h08, 7'h00, 7'h00},
                12'h3DE, 32'h40, 3'b111);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
